// File: rtl/fp_pkg.sv
// Shared binary32 constants and the unpacked-operand record used by the
// single-precision adder front end.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Default right-shifter ceiling: any larger shift empties a 24-bit mantissa.
  localparam int SHAMT_SAT = 24;

  // Operand after unpacking. exp_eff is 1 for zero/denormal inputs so that
  // denormals line up with the smallest normal exponent.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_eff;
    logic [MANT_W-1:0] mant;
    logic              is_nan;
    logic              is_inf;
    logic              is_zero;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 unpacker: splits sign/exponent/fraction, restores
// the hidden bit and classifies the operand.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]  x,
  output fp_unpacked_t u
);

  logic [EXP_W-1:0]  exp_raw;
  logic [FRAC_W-1:0] frac;
  logic              exp_zero;
  logic              exp_max;

  assign exp_raw  = x[30:23];
  assign frac     = x[22:0];
  assign exp_zero = (exp_raw == '0);
  assign exp_max  = (exp_raw == EXP_MAX);

  assign u.sign    = x[31];
  assign u.exp_eff = exp_zero ? 8'd1 : exp_raw;
  assign u.mant    = {~exp_zero, frac};
  assign u.is_nan  = exp_max && (frac != '0);
  assign u.is_inf  = exp_max && (frac == '0);
  assign u.is_zero = exp_zero && (frac == '0);

endmodule

// File: rtl/fp_add_prealign.sv
// Two-stage front end of the binary32 adder: unpack, magnitude compare and
// swap, then exponent difference saturated to the alignment shifter's range.
// Optional build macro FP_PREALIGN_STICKY_EN adds a registered sticky output
// (OR of the small-mantissa bits the shifter will discard).
module fp_add_prealign #(
  parameter int SHAMT_SAT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] big_mant,
  output logic [23:0] small_mant,
  output logic [7:0]  shamt,
  output logic [7:0]  exp_big,
  output logic        sign_big,
  output logic        eff_sub,
  output logic        swapped,
  output logic        is_nan,
  output logic        is_inf
`ifdef FP_PREALIGN_STICKY_EN
  ,
  output logic        sticky
`endif
);

  import fp_pkg::*;

  // Clamp the exponent difference to the shifter's useful range.
  function automatic logic [7:0] sat_shamt(input logic [7:0] d);
    if (d >= 8'(SHAMT_SAT)) return 8'(SHAMT_SAT);
    else                    return d;
  endfunction

`ifdef FP_PREALIGN_STICKY_EN
  // OR of the mantissa bits below the shift point; a shift of 24 or more
  // discards the whole mantissa.
  function automatic logic sticky_bits(input logic [MANT_W-1:0] m,
                                       input logic [7:0]        sh);
    logic [MANT_W-1:0] mask;
    if (sh >= 8'(MANT_W)) mask = '1;
    else                  mask = (MANT_W'(1) << sh) - MANT_W'(1);
    return |(m & mask);
  endfunction
`endif

  logic adv_p1, adv_p2;
  logic vld_p1, vld_p2;

  fp_unpacked_t ua, ub;
  logic         swap_p0;
  fp_unpacked_t big_p1, small_p1;
  logic         swapped_p1;

  logic [7:0] diff_p1;
  logic [7:0] shamt_nxt;
  logic       eff_sub_nxt;
  logic       nan_nxt;
  logic       inf_nxt;

  // is_zero is carried for downstream users of the record but not needed here.
  logic unused_zero;
  assign unused_zero = &{1'b0, big_p1.is_zero, small_p1.is_zero};

  // Handshake: each stage advances when it is empty or its consumer moves.
  assign adv_p2   = !vld_p2 || out_ready;
  assign adv_p1   = !vld_p1 || adv_p2;
  assign in_ready = adv_p1;
  assign out_valid = vld_p2;

  // ---- stage 0 -> 1: unpack both operands, apply op_sub to B, compare ----
  fp_unpack u_unpack_a (
    .x (a),
    .u (ua)
  );

  fp_unpack u_unpack_b (
    .x ({b[31] ^ op_sub, b[30:0]}),
    .u (ub)
  );

  // Strict compare so equal magnitudes keep A as the big operand.
  assign swap_p0 = (b[30:0] > a[30:0]);

  // Stage-1 valid tracks accepted inputs; cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)         vld_p1 <= 1'b0;
    else if (adv_p1) vld_p1 <= in_valid;
  end

  // Stage-1 data captures the ordered operand pair on each accepted input.
  always_ff @(posedge clk) begin
    if (adv_p1 && in_valid) begin
      big_p1     <= swap_p0 ? ub : ua;
      small_p1   <= swap_p0 ? ua : ub;
      swapped_p1 <= swap_p0;
    end
  end

  // ---- stage 1 -> 2: exponent difference, saturation, specials ----
  assign diff_p1     = big_p1.exp_eff - small_p1.exp_eff;
  assign shamt_nxt   = sat_shamt(diff_p1);
  assign eff_sub_nxt = big_p1.sign ^ small_p1.sign;
  assign nan_nxt     = big_p1.is_nan || small_p1.is_nan ||
                       (big_p1.is_inf && small_p1.is_inf && eff_sub_nxt);
  assign inf_nxt     = !nan_nxt && (big_p1.is_inf || small_p1.is_inf);

  // Stage-2 output register: zeroed on reset, holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      big_mant   <= '0;
      small_mant <= '0;
      shamt      <= '0;
      exp_big    <= '0;
      sign_big   <= 1'b0;
      eff_sub    <= 1'b0;
      swapped    <= 1'b0;
      is_nan     <= 1'b0;
      is_inf     <= 1'b0;
`ifdef FP_PREALIGN_STICKY_EN
      sticky     <= 1'b0;
`endif
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        big_mant   <= big_p1.mant;
        small_mant <= small_p1.mant;
        shamt      <= shamt_nxt;
        exp_big    <= big_p1.exp_eff;
        sign_big   <= big_p1.sign;
        eff_sub    <= eff_sub_nxt;
        swapped    <= swapped_p1;
        is_nan     <= nan_nxt;
        is_inf     <= inf_nxt;
`ifdef FP_PREALIGN_STICKY_EN
        sticky     <= sticky_bits(small_p1.mant, shamt_nxt);
`endif
      end
    end
  end

endmodule

// File: tb/tb_fp_add_prealign.sv
// Self-checking bench for fp_add_prealign: directed vectors, backpressure,
// mid-stream reset and a randomized stream against an arithmetic model.
module tb_fp_add_prealign;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        op_sub;
  logic        out_valid, out_ready;
  logic [23:0] big_mant, small_mant;
  logic [7:0]  shamt, exp_big;
  logic        sign_big, eff_sub, swapped, is_nan, is_inf;
`ifdef FP_PREALIGN_STICKY_EN
  logic        sticky;
`endif

  always #5 clk = ~clk;

  fp_add_prealign dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op_sub     (op_sub),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .big_mant   (big_mant),
    .small_mant (small_mant),
    .shamt      (shamt),
    .exp_big    (exp_big),
    .sign_big   (sign_big),
    .eff_sub    (eff_sub),
    .swapped    (swapped),
    .is_nan     (is_nan),
    .is_inf     (is_inf)
`ifdef FP_PREALIGN_STICKY_EN
    ,
    .sticky     (sticky)
`endif
  );

  typedef struct packed {
    logic [23:0] big_mant;
    logic [23:0] small_mant;
    logic [7:0]  shamt;
    logic [7:0]  exp_big;
    logic        sign_big;
    logic        eff_sub;
    logic        swapped;
    logic        is_nan;
    logic        is_inf;
    logic        sticky;
  } exp_t;

  int    checks = 0;
  int    failures = 0;
  int    delivered = 0;
  exp_t  q[$];
  logic  ovr_en = 1'b0;
  exp_t  ovr_val;

  // Reference: result fields straight from the binary32 rules, in integers.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic sub);
    exp_t e;
    int ex, ey, mx, my, eex, eey, sx, sy;
    int bm, sm, be, se, bs, ss, d, sh;
    bit sw, nx, ny, ix, iy, nan, inf;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    mx  = (ex == 0) ? int'(x[22:0]) : int'(x[22:0]) + (1 << 23);
    my  = (ey == 0) ? int'(y[22:0]) : int'(y[22:0]) + (1 << 23);
    eex = (ex == 0) ? 1 : ex;
    eey = (ey == 0) ? 1 : ey;
    sx  = int'(x[31]);
    sy  = int'(y[31] ^ sub);
    sw  = (int'(y[30:0]) > int'(x[30:0]));
    bm = sw ? my : mx;   sm = sw ? mx : my;
    be = sw ? eey : eex; se = sw ? eex : eey;
    bs = sw ? sy : sx;   ss = sw ? sx : sy;
    d  = be - se;
    sh = (d >= 24) ? 24 : d;
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    nan = nx || ny || (ix && iy && (bs != ss));
    inf = !nan && (ix || iy);
    e.big_mant   = 24'(bm);
    e.small_mant = 24'(sm);
    e.shamt      = 8'(sh);
    e.exp_big    = 8'(be);
    e.sign_big   = bs[0];
    e.eff_sub    = (bs != ss);
    e.swapped    = sw;
    e.is_nan     = nan;
    e.is_inf     = inf;
`ifdef FP_PREALIGN_STICKY_EN
    e.sticky     = ((sm % (1 << sh)) != 0);
`else
    e.sticky     = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t mk(input logic [23:0] bm, input logic [23:0] sm,
                              input logic [7:0] sh, input logic [7:0] eb,
                              input logic sb, input logic es, input logic sw,
                              input logic nan, input logic inf, input logic st);
    exp_t e;
    e.big_mant = bm; e.small_mant = sm; e.shamt = sh; e.exp_big = eb;
    e.sign_big = sb; e.eff_sub = es; e.swapped = sw;
    e.is_nan = nan; e.is_inf = inf;
`ifdef FP_PREALIGN_STICKY_EN
    e.sticky = st;
`else
    e.sticky = 1'b0 & st;
`endif
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t e;
    e.big_mant = big_mant; e.small_mant = small_mant; e.shamt = shamt;
    e.exp_big = exp_big; e.sign_big = sign_big; e.eff_sub = eff_sub;
    e.swapped = swapped; e.is_nan = is_nan; e.is_inf = is_inf;
`ifdef FP_PREALIGN_STICKY_EN
    e.sticky = sticky;
`else
    e.sticky = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive at the falling edge, resolve both handshakes, advance.
  task automatic cycle(input logic iv, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic ordy, output logic acc);
    in_valid = iv; a = av; b = bv; op_sub = sv; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 70'(out_valid), 70'(0));
      else begin
        chk("out_data", observed(), q[0]);
        void'(q.pop_front());
        delivered++;
      end
    end
    if (acc) q.push_back(ovr_en ? ovr_val : model(av, bv, sv));
    @(negedge clk);
  endtask

  task automatic issue_ovr(input logic [31:0] av, input logic [31:0] bv,
                           input logic sv, input exp_t e);
    logic acc;
    int n;
    acc = 1'b0; n = 0;
    ovr_en = 1'b1; ovr_val = e;
    while (!acc && n < 10) begin
      cycle(1'b1, av, bv, sv, 1'b1, acc);
      n++;
    end
    ovr_en = 1'b0;
    chk("issue_accept", 70'(acc), 70'(1));
  endtask

  task automatic drain(input string tag);
    logic acc;
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
      n++;
    end
    chk(tag, 70'(q.size()), 70'(0));
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return r;
      1: return {r[31], 8'h00, r[22:0]};
      2: return {r[31], 31'h0};
      3: return {r[31], 8'hFF, 23'h0};
      4: return {r[31], 8'hFF, r[22:1], 1'b1};
      5: return {r[31], 8'(8'h78 + 8'(r[26:23])), r[22:0]};
      6: return {r[31], 8'hFE, r[22:0]};
      default: return {r[31], 8'h7F, r[22:0]};
    endcase
  endfunction

  logic        acc;
  logic [31:0] ops_a[4], ops_b[4];
  logic        ops_s[4];
  int          idx, dstart;
  logic        pend, rv, rs;
  logic [31:0] ra, rb;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op_sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 70'(out_valid), 70'(0));
    chk("rst_data", observed(), 70'(0));
    chk("rst_in_ready", 70'(in_ready), 70'(1));
    @(negedge clk);

    // Latency: first result appears two edges after acceptance.
    ovr_en = 1'b1;
    ovr_val = mk(24'hC00000, 24'h800000, 8'd0, 8'h7F, 0, 0, 0, 0, 0, 0);
    cycle(1'b1, 32'h3FC00000, 32'h3F800000, 1'b0, 1'b1, acc);
    ovr_en = 1'b0;
    chk("t1_accept", 70'(acc), 70'(1));
    chk("lat_edge1", 70'(out_valid), 70'(0));
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    chk("lat_edge2", 70'(out_valid), 70'(1));

    // Directed vectors issued back to back.
    issue_ovr(32'h3F800000, 32'h41200000, 1'b1,
              mk(24'hA00000, 24'h800000, 8'd3, 8'h82, 1, 1, 1, 0, 0, 0));
    issue_ovr(32'h4B000000, 32'h33800000, 1'b0,
              mk(24'h800000, 24'h800000, 8'd24, 8'h96, 0, 0, 0, 0, 0, 1));
    issue_ovr(32'h3F800001, 32'h3E800000, 1'b0,
              mk(24'h800001, 24'h800000, 8'd2, 8'h7F, 0, 0, 0, 0, 0, 0));
    issue_ovr(32'h00000001, 32'h00800000, 1'b0,
              mk(24'h800000, 24'h000001, 8'd0, 8'h01, 0, 0, 1, 0, 0, 0));
    issue_ovr(32'h00000000, 32'h80000000, 1'b0,
              mk(24'h000000, 24'h000000, 8'd0, 8'h01, 0, 1, 0, 0, 0, 0));
    issue_ovr(32'h7F7FFFFF, 32'h00000000, 1'b0,
              mk(24'hFFFFFF, 24'h000000, 8'd24, 8'hFE, 0, 0, 0, 0, 0, 0));
    issue_ovr(32'h7F800000, 32'h7F800000, 1'b1,
              mk(24'h800000, 24'h800000, 8'd0, 8'hFF, 0, 1, 0, 1, 0, 0));
    issue_ovr(32'h7F800000, 32'h3F800000, 1'b0,
              mk(24'h800000, 24'h800000, 8'd24, 8'hFF, 0, 0, 0, 0, 1, 1));
    drain("directed_drain");

    // Backpressure: only two fit while the output is stalled.
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = rand_op(); ops_b[i] = rand_op(); ops_s[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    dstart = delivered;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, ops_a[idx], ops_b[idx], ops_s[idx], 1'b0, acc);
      if (acc) idx++;
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold_valid", 70'(out_valid), 70'(1));
      chk("bp_hold_data", observed(), (q.size() > 0) ? q[0] : exp_t'(0));
      chk("bp_in_ready", 70'(in_ready), 70'(0));
      cycle(1'b1, ops_a[idx], ops_b[idx], ops_s[idx], 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 70'(idx), 70'(2));
    cycle(1'b1, ops_a[idx], ops_b[idx], ops_s[idx], 1'b1, acc);
    chk("bp_no_bubble", 70'(acc), 70'(1));
    if (acc) idx++;
    for (int n = 0; n < 20 && idx < 4; n++) begin
      cycle(1'b1, ops_a[idx], ops_b[idx], ops_s[idx], 1'b1, acc);
      if (acc) idx++;
    end
    drain("bp_drain");
    chk("bp_delivered", 70'(delivered - dstart), 70'(4));

    // Reset with two entries in flight discards them.
    for (int i = 0; i < 2; i++)
      cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", 70'(out_valid), 70'(0));
    q.delete();
    rst = 1'b0;
    #1;
    chk("rst_mid_in_ready", 70'(in_ready), 70'(1));
    @(negedge clk);

    // Randomized stream with random stalls on both sides.
    pend = 1'b0; ra = '0; rb = '0; rs = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        ra = rand_op();
        rb = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), ra[30:0]} : rand_op();
        rs = 1'($urandom_range(0, 1));
        pend = 1'b1;
      end
      rv = ($urandom_range(0, 3) != 0);
      cycle(rv, ra, rb, rs, ($urandom_range(0, 3) != 0), acc);
      if (acc) pend = 1'b0;
    end
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add_prealign.md
Name: fp_add_prealign

Overview:
- Two-stage pipelined front end of the single-precision FP adder.
- Accepts two IEEE-754 binary32 operands and an add/sub opcode, then unpacks, compares magnitudes and swaps so the larger operand is "big".
- Produces the 24-bit mantissas, the exponent difference saturated to the right-shifter's range, and sign/special-case flags.
- Directly feeds the 24-bit mantissa alignment right shifter (small_mant -> shifter data input, shamt -> shift amount); valid/ready handshake on both sides.

Parameters:
- SHAMT_SAT, 24, saturation ceiling for shamt; any difference >= 24 shifts the full mantissa out.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept this cycle
- a  input  32  operand A, binary32
- b  input  32  operand B, binary32
- op_sub  input  1  1 = A - B, 0 = A + B
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- big_mant  output  24  hidden bit + fraction of larger-magnitude operand
- small_mant  output  24  hidden bit + fraction of smaller-magnitude operand (to shifter)
- shamt  output  8  exp_big - exp_small, saturated to SHAMT_SAT
- exp_big  output  8  effective exponent of larger operand
- sign_big  output  1  sign of larger operand (after op_sub applied to B)
- eff_sub  output  1  effective subtraction (signs differ after op_sub)
- swapped  output  1  1 when B was the larger operand
- is_nan  output  1  result is NaN
- is_inf  output  1  result is infinity (not NaN)

Behaviour:
- Reset: both stage valids cleared; out_valid=0; all data outputs 0; in_ready=1 in the first cycle after reset deasserts.
- Handshake:
  - Transfer on valid&&ready at each side.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready; no combinational in_valid->out_valid path.
  - Latency 2 cycles with no stall; throughput 1/cycle.
  - While stalled, stage registers and all outputs hold stable.
  - out_valid never drops without a transfer, except on rst.
- Stage 1 (unpack/compare/swap):
  - Per operand: exp==0 -> hidden bit 0, effective exponent 1 (denormal/zero); otherwise hidden bit 1, effective exponent = exp.
  - B sign is XORed with op_sub.
  - Magnitude compare uses {exp, frac} unsigned (31 bits); B strictly greater -> swap. Ties keep A as big.
  - Registers: big/small mantissas, effective exponents, signs, swapped, special flags.
- Stage 2 (difference/saturate):
  - diff = exp_big_eff - exp_small_eff, computed 8-bit, never negative after swap.
  - shamt = (diff >= SHAMT_SAT) ? SHAMT_SAT : diff.
  - eff_sub = sign_big ^ sign_small.
- Specials:
  - is_nan = either operand NaN (exp=255, frac!=0), or both infinite with eff_sub.
  - is_inf = !is_nan && either operand infinite.
  - Mantissa/shamt outputs are computed normally and are don't-care to downstream when a special flag is set.
- Boundaries:
  - Zero operands are treated as denormals; +0 + -0 passes eff_sub=1, big = A.
  - diff = 254 max, no wrap.
  - rst mid-stream discards in-flight entries; out_valid=0 the following cycle.
  - Simultaneous input accept and output drain with both stages full proceeds without bubble.

Optional Feature:
- FP_PREALIGN_STICKY_EN:
  - When defined: adds output port sticky (1 bit), registered in stage 2 with the other outputs.
  - sticky = OR of the small_mant bits that the right shift by shamt discards, i.e. small_mant[shamt-1:0]; when shamt=24 it is the OR of all 24 bits; shamt=0 gives 0.
  - Needed for round-to-nearest-even downstream because the shifter drops those bits.
  - When not defined: port absent, no logic.

Decomposition:
- Package fp_pkg holds:
  - constants EXP_W=8, FRAC_W=23, MANT_W=24, EXP_MAX=8'hFF, SHAMT_SAT default 24;
  - typedef fp_unpacked_t {sign, exp_eff[7:0], mant[23:0], is_nan, is_inf, is_zero}.
- One combinational sub-module fp_unpack (binary32 -> fp_unpacked_t), instantiated twice in stage 1.
- Pipeline control and stage registers live in the top module.

Test Plan:
- a=0x3FC00000, b=0x3F800000, op_sub=0, out_ready=1 -> 2 cycles later: big_mant=0xC00000, small_mant=0x800000, shamt=0, exp_big=0x7F, swapped=0, eff_sub=0.
- a=0x3F800000, b=0x41200000, op_sub=1 -> big_mant=0xA00000, small_mant=0x800000, exp_big=0x82, shamt=3, swapped=1, sign_big=1, eff_sub=1.
- a=0x4B000000, b=0x33800000 -> diff 47: shamt=24, exp_big=0x96; with FP_PREALIGN_STICKY_EN, sticky=1. Then a=0x3F800001, b=0x3E800000 -> shamt=2, small_mant=0x800000, sticky=0.
- Denormal: a=0x00000001, b=0x00800000 -> swapped=1, big_mant=0x800000, small_mant=0x000001, exp_big=1, shamt=0.
- Backpressure: issue 4 back-to-back ops with out_ready=0 -> exactly 2 accepted, then in_ready=0; out_valid=1 with stable outputs for 4 cycles. Release out_ready -> all 4 delivered in order, no loss or duplicate.
- Specials/reset: a=b=0x7F800000, op_sub=1 -> is_nan=1, is_inf=0. a=0x7F800000, b=0x3F800000 -> is_inf=1. Assert rst with 2 in flight -> out_valid=0 the next cycle, in_ready=1 after release.
